// File: rtl/apb_master_pipe.sv
// APB4 master: one APB transfer per accepted command, response returned over a
// valid/ready channel, with an optional bounded wait on PREADY.
module apb_master_pipe #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  // command channel
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  // response channel
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  // APB
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam bit        TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  // Held low while reset is asserted so the command side never sees a ready
  // from a master that is being cleared.
  assign cmd_ready = (state == IDLE) && !reset;

  // NOTE: every register here is state, so all assignments are non-blocking;
  // a blocking assignment would let later statements see the new value early.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      paddr       <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pstrb       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            paddr   <= cmd_addr;
            pwrite  <= cmd_write;
            pwdata  <= cmd_wdata;
            pstrb   <= cmd_write ? cmd_strb : '0;
            psel    <= 1'b1;
            penable <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          // pready is tested first so a completion on the last allowed cycle
          // beats the timeout.
          if (pready) begin
            rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (TO_EN && (wait_cnt == TO_LAST)) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_master_pipe.md
Name: apb_master_pipe

Overview:
- Parametrised APB4 master, successor to the fixed 8-bit single-address master.
- Accepts commands over a valid/ready interface: read/write, full address, write data and byte strobes.
- Runs one APB transfer per command, honouring PREADY wait states and PSLVERR.
- Returns read data and status over a valid/ready response channel.
- Bounded-wait timeout terminates transfers to hung slaves.
- Sits between a local bus/CPU-side agent and an APB peripheral fabric.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr/paddr (legal 8..32)
DATA_WIDTH, 32, width of data buses (legal 8, 16, 32)
TIMEOUT, 16, max consecutive ACCESS cycles with pready=0 before abort; 0 disables timeout (legal 0..255)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  master can accept command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  transfer address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  DATA_WIDTH/8  write byte strobes
rsp_valid  out  1  response present
rsp_ready  in  1  response consumer ready
rsp_rdata  out  DATA_WIDTH  read data (0 for writes/errors)
rsp_err  out  1  PSLVERR seen or timeout
rsp_timeout  out  1  transfer aborted by timeout
paddr  out  ADDR_WIDTH  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB strobes
prdata  in  DATA_WIDTH  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Reset: all outputs 0; state=IDLE; timeout counter 0. Asserting reset mid-transfer drops psel/penable immediately and discards any pending response.
- All outputs are registered except cmd_ready, which is a decode of state==IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: capture paddr=cmd_addr, pwrite=cmd_write, pwdata=cmd_wdata.
  - Capture pstrb=cmd_strb for writes; force pstrb=0 for reads.
  - psel<=1, penable<=0, go SETUP.
- SETUP: penable<=1; clear counter; go ACCESS.
- ACCESS, pready=1:
  - Capture rsp_rdata = (read && !pslverr) ? prdata : 0; rsp_err=pslverr; rsp_timeout=0.
  - psel<=0, penable<=0, rsp_valid<=1; go RESP.
- ACCESS, pready=0:
  - Increment counter.
  - If TIMEOUT!=0 and counter reaches TIMEOUT-1 on this cycle (i.e. TIMEOUT consecutive low-pready ACCESS cycles): rsp_rdata=0, rsp_err=1, rsp_timeout=1, psel<=0, penable<=0, rsp_valid<=1; go RESP.
  - Otherwise hold all APB outputs stable.
- RESP:
  - rsp_valid and response fields held stable until rsp_ready=1.
  - On handshake: rsp_valid<=0, rsp_err<=0, rsp_timeout<=0; go IDLE.
  - cmd_ready=0 throughout RESP.
- Latency: command accepted in cycle N gives SETUP at N+1, ACCESS at N+2; with zero wait states rsp_valid=1 at N+3. Each wait state adds one cycle. Minimum command-to-command spacing with rsp_ready tied high is 4 cycles.
- APB outputs paddr/pwrite/pwdata/pstrb stay unchanged from SETUP through the end of ACCESS. After a transfer they keep their last values; only psel/penable return to 0.
- Timeout and pready arriving on the same cycle: pready wins, normal completion.
- pslverr is sampled only when pready=1 in ACCESS; ignored otherwise.
- DATA_WIDTH=8 gives a 1-bit strobe; cmd_addr passes unmodified, with no alignment checking.

Test Plan:
- Zero-wait write: cmd addr=0x0000_0010, wdata=0xDEADBEEF, strb=0xF; pready=1 → SETUP and ACCESS each one cycle; rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: addr=0x20, slave drives prdata=0x1234_5678 with pready on 4th ACCESS cycle → rsp_rdata=0x12345678 at accept+6; pstrb=0 throughout; paddr stable.
- Slave error: read with pslverr=1 at pready → rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Timeout: TIMEOUT=4, pready held 0 → psel/penable drop after 4 ACCESS cycles; rsp_err=1, rsp_timeout=1. Repeat with TIMEOUT=0 and 100-cycle stall → no abort.
- Backpressure: rsp_ready=0 for 5 cycles → rsp_valid and data held stable, cmd_ready=0; second cmd_valid not accepted until cycle after handshake.
- Reset mid-ACCESS: assert reset during wait state → psel=penable=rsp_valid=0 immediately; after release, next command completes normally. Also run with DATA_WIDTH=16, ADDR_WIDTH=12.
